vga_sync_receiver: RTL and testbench

Receive-side VGA timing decoder: consumes the active-low HSYNC/VSYNC pair produced by the game's VGA timing generator (640x480@60, 25 MHz pixel clock) and recovers pixel coordinates, an active-video strobe, frame-start pulses and a lock indication. It sits on the looped-back sync outputs, feeding the on-board self-check and the frame-synchronous overlay logic. It must recognise a well-formed raster and flag any timing deviation.

---
 rtl/vga_sync_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Receive-side VGA timing decoder: recovers pixel coordinates, active-video strobe and lock from HSYNC/VSYNC.
// Optional measurement registers are enabled with `define VGA_SYNC_RX_MEASURE_EN.
module vga_sync_receiver #(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 3
) (
  input  logic        Clk_25mhz,
  input  logic        Rst,
  input  logic        Hsync_in,
  input  logic        Vsync_in,
  output logic [9:0]  Pixel_x,
  output logic [9:0]  Pixel_y,
  output logic        Pixel_valid,
  output logic        Frame_start,
  output logic        Locked,
  output logic        Sync_err,
  output logic [10:0] Meas_h_total,
  output logic [9:0]  Meas_v_total
);

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_ACT_HI = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  logic [2:0]  hs_q, vs_q;
  logic        h_edge_q, v_edge_q;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        v_pend_q, v_pend_d;
  logic        frame_bad_q, frame_bad_d;
  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        boundary, line_err, frame_err, timeout, good_frame;
  logic [9:0]  px_d, py_d;
  logic        valid_d, fs_d, locked_d, err_d;

  // Two flops resynchronise the pins; the third holds the previous level for edge detection.
  always_ff @(posedge Clk_25mhz) begin
    if (Rst) begin
      hs_q     <= '0;
      vs_q     <= '0;
      h_edge_q <= 1'b0;
      v_edge_q <= 1'b0;
    end else begin
      hs_q     <= {hs_q[1:0], Hsync_in};
      vs_q     <= {vs_q[1:0], Vsync_in};
      h_edge_q <= ~hs_q[1] & hs_q[2];
      v_edge_q <= ~vs_q[1] & vs_q[2];
    end
  end

  always_comb begin
    boundary   = h_edge_q & (v_pend_q | v_edge_q);
    line_err   = h_edge_q & (h_cnt_q != H_LAST);
    frame_err  = boundary & (v_cnt_q != V_LAST);
    timeout    = ~h_edge_q & (h_cnt_q == 11'd2046);
    good_frame = boundary & ~line_err & ~frame_err & ~frame_bad_q;
  end

  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    v_pend_d    = v_pend_q;
    frame_bad_d = frame_bad_q;
    if (h_edge_q)              h_cnt_d = '0;
    else if (h_cnt_q != '1)    h_cnt_d = h_cnt_q + 11'd1;
    if (boundary) begin
      v_cnt_d     = '0;
      v_pend_d    = 1'b0;
      frame_bad_d = 1'b0;
    end else begin
      if (v_edge_q)                   v_pend_d    = 1'b1;
      if (h_edge_q && v_cnt_q != '1)  v_cnt_d     = v_cnt_q + 10'd1;
      if (line_err)                   frame_bad_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_25mhz) begin
    if (Rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      v_pend_q    <= 1'b0;
      frame_bad_q <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      v_pend_q    <= v_pend_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  always_ff @(posedge Clk_25mhz) begin
    if (Rst) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // A frame only counts toward lock if no line inside it and not its own length was off.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (boundary) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (timeout) begin
          state_d = SEARCH;
          good_d  = '0;
        end else if (line_err || frame_err) begin
          good_d = '0;
        end else if (good_frame) begin
          if (good_q + 4'd1 == LOCK_N) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_d = SEARCH;
          good_d  = '0;
        end else if (line_err || frame_err) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  always_comb begin
    valid_d  = (state_q == LOCKED) &&
               (h_cnt_q >= H_ACT_LO) && (h_cnt_q < H_ACT_HI) &&
               (v_cnt_q >= V_ACT_LO) && (v_cnt_q < V_ACT_HI);
    px_d     = valid_d ? 10'(h_cnt_q - H_ACT_LO) : '0;
    py_d     = valid_d ? (v_cnt_q - V_ACT_LO) : '0;
    locked_d = (state_d == LOCKED);
    fs_d     = boundary & (state_d == LOCKED);
    err_d    = (state_q == LOCKED) & (timeout | line_err | frame_err);
  end

  always_ff @(posedge Clk_25mhz) begin
    if (Rst) begin
      Pixel_x     <= '0;
      Pixel_y     <= '0;
      Pixel_valid <= 1'b0;
      Frame_start <= 1'b0;
      Locked      <= 1'b0;
      Sync_err    <= 1'b0;
    end else begin
      Pixel_x     <= px_d;
      Pixel_y     <= py_d;
      Pixel_valid <= valid_d;
      Frame_start <= fs_d;
      Locked      <= locked_d;
      Sync_err    <= err_d;
    end
  end

`ifdef VGA_SYNC_RX_MEASURE_EN
  logic [10:0] meas_h_q;
  logic [9:0]  meas_v_q;

  always_ff @(posedge Clk_25mhz) begin
    if (Rst) begin
      meas_h_q <= '0;
      meas_v_q <= '0;
    end else begin
      if (h_edge_q) meas_h_q <= h_cnt_q + 11'd1;
      if (boundary) meas_v_q <= v_cnt_q + 10'd1;
    end
  end

  assign Meas_h_total = meas_h_q;
  assign Meas_v_total = meas_v_q;
`else
  assign Meas_h_total = '0;
  assign Meas_v_total = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 20x12 raster so full frames stay short.
module tb_vga_sync_receiver;

  localparam int HS = 4, HB = 3, HA = 8, HT = 20;
  localparam int VS = 2, VB = 3, VA = 4, VT = 12;
  localparam int LF = 3;
`ifdef VGA_SYNC_RX_MEASURE_EN
  localparam int MEAS_ON = 1;
`else
  localparam int MEAS_ON = 0;
`endif

  logic        clk, rst, hs, vs;
  logic [9:0]  px, py;
  logic        valid, fstart, locked, serr;
  logic [10:0] meas_h;
  logic [9:0]  meas_v;

  vga_sync_receiver #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .Clk_25mhz(clk), .Rst(rst), .Hsync_in(hs), .Vsync_in(vs),
    .Pixel_x(px), .Pixel_y(py), .Pixel_valid(valid), .Frame_start(fstart),
    .Locked(locked), .Sync_err(serr), .Meas_h_total(meas_h), .Meas_v_total(meas_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation counters sampled on the falling edge.
  int n_valid = 0, n_fs = 0, n_err = 0, sum_x = 0, sum_y = 0;
  int fx = -1, fy = -1, lx = -1, ly = -1, fcyc = 0;
  bit want_first = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      n_valid = n_valid + 1;
      sum_x   = sum_x + int'(px);
      sum_y   = sum_y + int'(py);
      lx      = int'(px);
      ly      = int'(py);
      if (want_first) begin
        fx = int'(px);
        fy = int'(py);
        fcyc = cyc;
        want_first = 1'b0;
      end
    end
    if (fstart) begin
      n_fs = n_fs + 1;
      want_first = 1'b1;
    end
    if (serr) n_err = n_err + 1;
  end

  int checks = 0, errors = 0;
  int t_fall = 0, t_act = 0, meas_snap = 0;
  bit early = 1'b0;
  int v0, f0, e0, sx0, sy0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic line(input int len, input bit vlow, input bit vdrop);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) begin
        hs = 1'b0;
        vs = ~vlow;
        t_fall = cyc;
      end else if (i == HS) begin
        hs = 1'b1;
      end
      if (vdrop && i == len - 1) vs = 1'b0;
    end
  endtask

  task automatic frame(input int nl, input int long_idx);
    for (int l = 0; l < nl; l++) begin
      line((l == long_idx) ? HT + 1 : HT, l < VS, early && (l == nl - 1));
      if (l == VS + VB) t_act = t_fall;
      if (l == long_idx + 1) meas_snap = int'(meas_h);
    end
  endtask

  task automatic snap();
    v0 = n_valid; f0 = n_fs; e0 = n_err; sx0 = sum_x; sy0 = sum_y;
  endtask

  task automatic check_locked_frame(input string pfx);
    check({pfx, "_locked"}, 32'(locked), 1);
    check({pfx, "_fs_count"}, n_fs - f0, 1);
    check({pfx, "_valid_count"}, n_valid - v0, HA * VA);
    check({pfx, "_first_x"}, fx, 0);
    check({pfx, "_first_y"}, fy, 0);
    check({pfx, "_last_x"}, lx, HA - 1);
    check({pfx, "_last_y"}, ly, VA - 1);
    check({pfx, "_first_valid_delay"}, fcyc - t_act, 1 + 4 + HS + HB);
    check({pfx, "_sum_x"}, sum_x - sx0, VA * (HA * (HA - 1) / 2));
    check({pfx, "_sum_y"}, sum_y - sy0, HA * (VA * (VA - 1) / 2));
    check({pfx, "_sync_err"}, n_err - e0, 0);
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_px", 32'(px), 0);
    check("rst_py", 32'(py), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_fs", 32'(fstart), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(serr), 0);
    check("rst_meas_h", 32'(meas_h), 0);
    check("rst_meas_v", 32'(meas_v), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal raster: first boundary plus three good frames.
    snap();
    repeat (3) frame(VT, -1);
    check("acq_locked_early", 32'(locked), 0);
    check("acq_fs_none", n_fs - f0, 0);
    check("acq_valid_none", n_valid - v0, 0);
    snap();
    frame(VT, -1);
    check_locked_frame("nom");
    check("nom_meas_h", 32'(meas_h), MEAS_ON * HT);
    check("nom_meas_v", 32'(meas_v), MEAS_ON * VT);

    // One over-long line while locked.
    snap();
    frame(VT, VS + VB + 1);
    check("long_err_pulse", n_err - e0, 1);
    check("long_unlocked", 32'(locked), 0);
    check("long_meas_h", meas_snap, MEAS_ON * (HT + 1));
    snap();
    repeat (3) frame(VT, -1);
    check("relock_not_yet", 32'(locked), 0);
    frame(VT, -1);
    check("relock_locked", 32'(locked), 1);
    check("relock_fs", n_fs - f0, 1);
    check("relock_no_err", n_err - e0, 0);

    // Short frame while locked, then a short frame while checking.
    snap();
    frame(VT - 1, -1);
    frame(VT, -1);
    check("short_locked_err", n_err - e0, 1);
    check("short_locked_unlock", 32'(locked), 0);
    snap();
    frame(VT, -1);
    frame(VT - 1, -1);
    repeat (3) frame(VT, -1);
    check("short_check_no_lock", 32'(locked), 0);
    check("short_check_no_err", n_err - e0, 0);
    frame(VT, -1);
    check("short_check_relock", 32'(locked), 1);

    // Hsync stuck high past the counter limit.
    snap();
    repeat (2100) @(negedge clk);
    check("timeout_unlocked", 32'(locked), 0);
    check("timeout_no_valid", n_valid - v0, 0);
    check("timeout_err", n_err - e0, 1);
    repeat (3) frame(VT, -1);
    check("timeout_reacq_early", 32'(locked), 0);
    frame(VT, -1);
    check("timeout_reacq", 32'(locked), 1);

    // Reset mid-frame while locked, then reacquire with vsync one pixel early.
    frame(6, -1);
    check("prerst_locked", 32'(locked), 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_px", 32'(px), 0);
    check("midrst_py", 32'(py), 0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_fs", 32'(fstart), 0);
    check("midrst_err", 32'(serr), 0);
    check("midrst_meas_h", 32'(meas_h), 0);
    check("midrst_meas_v", 32'(meas_v), 0);
    repeat (5) @(negedge clk);
    early = 1'b1;
    @(negedge clk); vs = 1'b0;
    snap();
    repeat (3) frame(VT, -1);
    check("early_locked_early", 32'(locked), 0);
    check("early_fs_none", n_fs - f0, 0);
    snap();
    frame(VT, -1);
    check_locked_frame("early");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
